// File: rtl/inv2_pkg.sv
// Shared types and saturating helpers for the inv2_stream 2x2 matrix inverse.
// Build option INV2_ROUND_EN selects round-half-up on every fixed-point shift.
package inv2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DET,
      ST_RCP,
      ST_MUL,
      ST_OUT
   } state_e;

   // Clamp a wide signed value into the range of a w-bit two's complement word.
   function automatic logic signed [63:0] sat_n(input logic signed [63:0] x,
                                                 input int unsigned      w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   function automatic logic signed [63:0] neg_sat(input logic signed [63:0] x,
                                                   input int unsigned      w);
      return sat_n(-x, w);
   endfunction

   function automatic logic signed [63:0] rnd_const(input int unsigned frac);
      return 64'sd1 <<< (frac - 1);
   endfunction

endpackage

// File: rtl/goldschmidt_recip.sv
// Combinational Goldschmidt reciprocal: 2^(2*FRAC)/den in Q(FRAC), saturated to N bits.
// The magnitude is normalised to [0.5,1) and refined over a fixed number of iterations.
module goldschmidt_recip #(
   parameter int unsigned N    = 20,
   parameter int unsigned FRAC = 10
) (
   input  logic signed [N-1:0] den,
   output logic signed [N-1:0] recip
);

   localparam int unsigned GF   = 30;
   localparam int unsigned ITER = 5;

   logic [N-1:0]  mag;
   logic [N-1:0]  norm;
   logic [63:0]   nq;
   logic [63:0]   dq;
   logic [63:0]   f;
   logic [127:0]  wide;
   logic [127:0]  max_mag;
   int unsigned   msb;
   int unsigned   sh;

   always_comb begin
      mag = den[N-1] ? (~den + 1'b1) : den;
      msb = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (mag[i]) msb = i;
      end
      sh   = N - 1 - msb;
      norm = mag << sh;
      dq   = 64'(norm) << (GF - N);
      nq   = 64'd1 << GF;
      for (int unsigned it = 0; it < ITER; it++) begin
         f  = (64'd2 << GF) - dq;
         nq = (nq * f) >> GF;
         dq = (dq * f) >> GF;
      end
      // Undo the normalisation shift and round to nearest in one step.
      wide    = ((128'(nq) << (2 * FRAC + sh)) + (128'd1 << (GF + N - 1))) >> (GF + N);
      max_mag = 128'((64'd1 << (N - 1)) - 64'd1);
      if (mag == '0 || wide > max_mag) wide = max_mag;
      recip = den[N-1] ? -$signed(N'(wide)) : $signed(N'(wide));
   end

endmodule

// File: rtl/inv2_prod_lane.sv
// One fixed-point product lane: multiply, optional round (INV2_ROUND_EN),
// arithmetic shift by FRAC, then saturate to OW bits.
module inv2_prod_lane
   import inv2_pkg::*;
#(
   parameter int unsigned N    = 20,
   parameter int unsigned FRAC = 10,
   parameter int unsigned OW   = N
) (
   input  logic signed [N-1:0]  x,
   input  logic signed [N-1:0]  y,
   output logic signed [OW-1:0] p
);

   logic signed [63:0] prod;
   logic signed [63:0] shifted;

   always_comb begin
      prod = 64'(x) * 64'(y);
`ifdef INV2_ROUND_EN
      prod = prod + rnd_const(FRAC);
`else
      prod = prod + 64'sd0;
`endif
      shifted = prod >>> FRAC;
      p       = OW'(sat_n(shifted, OW));
   end

endmodule

// File: rtl/inv2_stream.sv
// Handshaked 2x2 fixed-point matrix inverse with singular detection.
// Build option INV2_ROUND_EN: round-half-up on det products and output lanes.
module inv2_stream
   import inv2_pkg::*;
#(
   parameter int unsigned N       = 20,
   parameter int unsigned FRAC    = 10,
   parameter int unsigned NMUL    = 2,
   parameter int unsigned DET_EPS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   input  logic signed [N-1:0] c,
   input  logic signed [N-1:0] d,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] IA,
   output logic signed [N-1:0] IB,
   output logic signed [N-1:0] IC,
   output logic signed [N-1:0] ID,
   output logic                singular,
   output logic signed [N-1:0] det_out
);

   state_e              state_q, state_d;
   logic signed [N-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   logic signed [N-1:0] det_q, det_d, recip_q, recip_d;
   logic signed [N-1:0] res_q [4];
   logic signed [N-1:0] res_d [4];
   logic [1:0]          k_q, k_d;
   logic                singular_q, singular_d;
   logic                out_valid_q, out_valid_d;
   logic                in_ready_q, in_ready_d;

   logic signed [2*N-1:0] p_ad, p_bc;
   logic signed [N-1:0]   recip_w;
   logic signed [N-1:0]   op [4];
   logic signed [N-1:0]   lane_x [NMUL];
   logic signed [N-1:0]   lane_p [NMUL];
   logic signed [63:0]    det_full, det_mag;

   inv2_prod_lane #(.N(N), .FRAC(FRAC), .OW(2*N)) u_ad (.x(a_q), .y(d_q), .p(p_ad));
   inv2_prod_lane #(.N(N), .FRAC(FRAC), .OW(2*N)) u_bc (.x(b_q), .y(c_q), .p(p_bc));

   goldschmidt_recip #(.N(N), .FRAC(FRAC)) u_recip (.den(det_q), .recip(recip_w));

   for (genvar j = 0; j < NMUL; j++) begin : g_lane
      inv2_prod_lane #(.N(N), .FRAC(FRAC), .OW(N)) u_lane (
         .x(lane_x[j]), .y(recip_q), .p(lane_p[j])
      );
   end

   always_comb begin
      op[0] = d_q;
      op[1] = N'(neg_sat(64'(b_q), N));
      op[2] = N'(neg_sat(64'(c_q), N));
      op[3] = a_q;
      for (int unsigned j = 0; j < NMUL; j++) lane_x[j] = op[k_q + 2'(j)];
      det_full = 64'(p_ad) - 64'(p_bc);
      det_mag  = det_q[N-1] ? -64'(det_q) : 64'(det_q);
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      d_d         = d_q;
      det_d       = det_q;
      recip_d     = recip_q;
      res_d       = res_q;
      k_d         = k_q;
      singular_d  = singular_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               c_d        = c;
               d_d        = d;
               singular_d = 1'b0;
               state_d    = ST_DET;
            end
         end
         ST_DET: begin
            det_d   = N'(sat_n(det_full, N));
            state_d = ST_RCP;
         end
         ST_RCP: begin
            if (det_mag <= 64'(DET_EPS)) begin
               for (int unsigned i = 0; i < 4; i++) res_d[i] = '0;
               singular_d = 1'b1;
               state_d    = ST_OUT;
            end else begin
               recip_d = recip_w;
               k_d     = '0;
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            for (int unsigned j = 0; j < NMUL; j++) res_d[k_q + 2'(j)] = lane_p[j];
            k_d = k_q + 2'(NMUL);
            if (3'(k_q) + 3'(NMUL) == 3'd4) state_d = ST_OUT;
         end
         ST_OUT: begin
            // out_valid rises one cycle after entering OUT, giving the registered result a full cycle.
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         det_q       <= '0;
         recip_q     <= '0;
         res_q       <= '{default: '0};
         k_q         <= '0;
         singular_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         d_q         <= d_d;
         det_q       <= det_d;
         recip_q     <= recip_d;
         res_q       <= res_d;
         k_q         <= k_d;
         singular_q  <= singular_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign singular  = singular_q;
   assign det_out   = det_q;
   assign IA        = res_q[0];
   assign IB        = res_q[1];
   assign IC        = res_q[2];
   assign ID        = res_q[3];

endmodule

// File: tb/tb_inv2_stream.sv
// Directed bench for inv2_stream: main instance NMUL=2, plus NMUL=1 and NMUL=4
// instances used only for latency checks.
module tb_inv2_stream;

   localparam int N = 20;

   logic clk = 1'b0;
   logic rst, in_valid, out_ready, in_valid_x, out_ready_x;
   logic signed [N-1:0] a, b, c, d;

   logic in_ready, out_valid, singular;
   logic signed [N-1:0] ia, ib, ic, id, det_out;

   logic in_ready1, out_valid1, singular1, in_ready4, out_valid4, singular4;
   logic signed [N-1:0] r1 [5];
   logic signed [N-1:0] r4 [5];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv2_stream #(.N(N), .FRAC(10), .NMUL(2), .DET_EPS(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
      .IA(ia), .IB(ib), .IC(ic), .ID(id), .singular(singular), .det_out(det_out)
   );

   inv2_stream #(.N(N), .FRAC(10), .NMUL(1), .DET_EPS(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready1),
      .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid1), .out_ready(out_ready_x),
      .IA(r1[0]), .IB(r1[1]), .IC(r1[2]), .ID(r1[3]), .singular(singular1), .det_out(r1[4])
   );

   inv2_stream #(.N(N), .FRAC(10), .NMUL(4), .DET_EPS(1)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready4),
      .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid4), .out_ready(out_ready_x),
      .IA(r4[0]), .IB(r4[1]), .IC(r4[2]), .ID(r4[3]), .singular(singular4), .det_out(r4[4])
   );

   task automatic check(input string tag, input longint got, input longint exp, input longint tol);
      checks++;
      if (got > exp + tol || got < exp - tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int av, input int bv, input int cv, input int dv);
      a = av[N-1:0];
      b = bv[N-1:0];
      c = cv[N-1:0];
      d = dv[N-1:0];
   endtask

   // Accept one matrix, scramble the inputs, then wait (bounded) for out_valid.
   task automatic run_main(input string t, input int av, input int bv, input int cv,
                           input int dv, input int exp_lat);
      int lat;
      set_in(av, bv, cv, dv);
      in_valid = 1'b1;
      check({t, "_in_ready"}, in_ready, 1, 0);
      tick();
      in_valid = 1'b0;
      set_in(777, -333, 91, -5);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({t, "_out_valid"}, out_valid, 1, 0);
      check({t, "_latency"}, lat, exp_lat, 0);
   endtask

   task automatic chk_res(input string t, input int e_det, input int e_ia, input int e_ib,
                          input int e_ic, input int e_id, input int e_sing);
      longint tol;
      tol = (e_sing != 0) ? 0 : 2;
      check({t, "_det"}, det_out, e_det, 0);
      check({t, "_singular"}, singular, e_sing, 0);
      check({t, "_IA"}, ia, e_ia, tol);
      check({t, "_IB"}, ib, e_ib, tol);
      check({t, "_IC"}, ic, e_ic, tol);
      check({t, "_ID"}, id, e_id, tol);
   endtask

   task automatic release_out(input string t);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({t, "_valid_drop"}, out_valid, 0, 0);
      check({t, "_ready_back"}, in_ready, 1, 0);
   endtask

   task automatic run_alt(input string t, input int av, input int bv, input int cv, input int dv,
                          input int e1, input int e4, input int e_sing);
      int l1, l4;
      logic s1, s4;
      l1 = 0;
      l4 = 0;
      s1 = 1'b0;
      s4 = 1'b0;
      set_in(av, bv, cv, dv);
      in_valid_x = 1'b1;
      check({t, "_ready1"}, in_ready1, 1, 0);
      check({t, "_ready4"}, in_ready4, 1, 0);
      tick();
      in_valid_x = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (out_valid1 && l1 == 0) begin l1 = n; s1 = singular1; end
         if (out_valid4 && l4 == 0) begin l4 = n; s4 = singular4; end
      end
      check({t, "_lat_nmul1"}, l1, e1, 0);
      check({t, "_lat_nmul4"}, l4, e4, 0);
      check({t, "_sing_nmul1"}, s1, e_sing, 0);
      check({t, "_sing_nmul4"}, s4, e_sing, 0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_valid_x = 1'b0;
      out_ready = 1'b0;
      out_ready_x = 1'b1;
      set_in(0, 0, 0, 0);
      repeat (3) tick();
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1, 0);
      check("rst_out_valid", out_valid, 0, 0);
      chk_res("rst", 0, 0, 0, 0, 0, 0);

      run_main("ident", 1024, 0, 0, 1024, 5);
      chk_res("ident", 1024, 1024, 0, 0, 1024, 0);
      release_out("ident");

      run_main("diag", 2048, 0, 0, 4096, 5);
      chk_res("diag", 8192, 512, 0, 0, 256, 0);
      release_out("diag");

      run_main("sing", 1024, 2048, 2048, 4096, 3);
      chk_res("sing", 0, 0, 0, 0, 0, 1);
      release_out("sing");

      run_main("eps1", 1, 0, 0, 1024, 3);
      chk_res("eps1", 1, 0, 0, 0, 0, 1);
      release_out("eps1");

      run_main("eps2", 2, 0, 0, 1024, 5);
      chk_res("eps2", 2, 524287, 0, 0, 1024, 0);
      release_out("eps2");

      run_main("swap", 0, 1024, 1024, 0, 5);
      chk_res("swap", -1024, 0, 1024, 1024, 0, 0);
      release_out("swap");

      run_main("negsat", 1024, -524288, 0, 1024, 5);
      chk_res("negsat", 1024, 1024, 524287, 0, 1024, 0);
      release_out("negsat");

      // det = 2^28 clamps to 524287; recip rounds to 2, so IA = ID = -524288*2 >>> 10.
      run_main("satdet", -524288, 0, 0, -524288, 5);
      chk_res("satdet", 524287, -1024, 0, 0, -1024, 0);
      release_out("satdet");

      run_main("bp", 1024, 0, 0, 1024, 5);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("bp_hold_valid", out_valid, 1, 0);
         check("bp_hold_ready", in_ready, 0, 0);
         check("bp_hold_IA", ia, 1024, 2);
         check("bp_hold_det", det_out, 1024, 0);
      end
      release_out("bp");
      run_main("b2b", 2048, 0, 0, 4096, 5);
      chk_res("b2b", 8192, 512, 0, 0, 256, 0);
      release_out("b2b");

      set_in(1024, 0, 0, 1024);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", out_valid, 0, 0);
      check("midrst_in_ready", in_ready, 1, 0);
      chk_res("midrst", 0, 0, 0, 0, 0, 0);
      run_main("postrst", 1024, 0, 0, 1024, 5);
      chk_res("postrst", 1024, 1024, 0, 0, 1024, 0);
      release_out("postrst");

      run_alt("alt_sing", 1024, 2048, 2048, 4096, 3, 3, 1);
      run_alt("alt_ident", 1024, 0, 0, 1024, 7, 4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
